// File: rtl/regfile_sequencer_pkg.sv
// regfile_sequencer_pkg
//   Shared definitions for the register-file sequencer: opcode encoding,
//   the 2-bit FSM state encoding, and the bit positions of the instruction
//   fields. Field helpers keep the slicing in one place.
package regfile_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MOV = 2'b10,
    OP_LI  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  // Instruction layout: op[7:6] rs[5:4] rt[3:2] rd[1:0]; LI immediate is [5:2].
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int RD_MSB  = 1;
  localparam int RD_LSB  = 0;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 2;

  function automatic op_e get_op(input logic [7:0] instr);
    return op_e'(instr[OP_MSB:OP_LSB]);
  endfunction

  function automatic logic [1:0] get_rs(input logic [7:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [1:0] get_rt(input logic [7:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [1:0] get_rd(input logic [7:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [3:0] get_imm(input logic [7:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if
//   Instruction handshake plus retirement status of the sequencer.
//   master : instruction source (drives instr_valid/instr, observes the rest)
//   slave  : the sequencer
//   Signals: instr_valid, instr[7:0], instr_ready, done, result[W-1:0],
//            carry, zero.
interface regfile_sequencer_if #(
  parameter int W = 8
);
  logic         instr_valid;
  logic [7:0]   instr;
  logic         instr_ready;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, result, carry, zero
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, result, carry, zero
  );
endinterface

// File: rtl/regfile_seq_alu.sv
// regfile_seq_alu
//   Combinational ALU for the sequencer.
//   op_i   : opcode
//   a_i    : operand A (rs value)
//   b_i    : operand B (rt value)
//   imm_i  : 4-bit immediate for LI
//   res_o  : W+1-bit result; bit W is carry (ADD) or borrow (SUB), 0 otherwise
//   zero_o : low W bits of the result are zero
module regfile_seq_alu
  import regfile_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   imm_i,
  output logic [W:0]   res_o,
  output logic         zero_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = {1'b0, a_i} + {1'b0, b_i};
      // The wrapped top bit of a zero-extended subtract is the borrow (a < b).
      OP_SUB:  res_o = {1'b0, a_i} - {1'b0, b_i};
      OP_MOV:  res_o = {1'b0, a_i};
      OP_LI:   res_o = {{(W - 3){1'b0}}, imm_i};
      default: res_o = '0;
    endcase
    zero_o = (res_o[W-1:0] == '0);
  end

endmodule

// File: rtl/register.sv
// register
//   4 x W register file with two combinational read ports and one
//   synchronous write port. Reset clears every entry.
//   Read1/Read2   : read addresses;  ReadD1/ReadD2 : read data
//   RegWrite      : write enable;    WriteR/WriteD : write address/data
module register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [1:0]   Read1,
  input  logic [1:0]   Read2,
  output logic [W-1:0] ReadD1,
  output logic [W-1:0] ReadD2,
  input  logic         RegWrite,
  input  logic [1:0]   WriteR,
  input  logic [W-1:0] WriteD
);

  logic [W-1:0] mem_q [4];

  // NOTE: this array is only four flops wide, so it is reset like any other
  // state; a large RAM would be left unreset and initialised by software.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else if (RegWrite) begin
      mem_q[WriteR] <= WriteD;
    end
  end

  assign ReadD1 = mem_q[Read1];
  assign ReadD2 = mem_q[Read2];

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Four-state multicycle initiator for the register file: accepts one
//   instruction per handshake, reads rs/rt, executes, writes rd.
//   clk, Reset          : clock, synchronous active-high reset
//   ifc (slave)         : instruction handshake and retirement status
//   Read1/Read2         : read addresses, loaded with rs/rt at handshake
//   ReadD1/ReadD2       : read data, captured during READ
//   RegWrite/WriteR/WriteD : write port, active in WRITE
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  regfile_sequencer_if.slave   ifc,
  output logic [1:0]           Read1,
  output logic [1:0]           Read2,
  input  logic [W-1:0]         ReadD1,
  input  logic [W-1:0]         ReadD2,
  output logic                 RegWrite,
  output logic [1:0]           WriteR,
  output logic [W-1:0]         WriteD
);

  state_e       state_q, state_d;
  logic [7:0]   instr_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] result_q;
  logic         carry_q, zero_q;
  logic [1:0]   read1_q, read2_q, write_r_q;
  logic [W:0]   alu_res;
  logic         alu_zero;
  logic         accept;

  regfile_seq_alu #(.W(W)) u_alu (
    .op_i   (get_op(instr_q)),
    .a_i    (a_q),
    .b_i    (b_q),
    .imm_i  (get_imm(instr_q)),
    .res_o  (alu_res),
    .zero_o (alu_zero)
  );

  // NOTE: every branch starts from a default, so no path leaves a signal
  // unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    ifc.instr_ready = 1'b0;
    RegWrite        = 1'b0;
    ifc.done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ifc.instr_ready = 1'b1;
        if (ifc.instr_valid) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: begin
        RegWrite = 1'b1;
        ifc.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    // Reset suppresses the handshake and any write in the very cycle it is
    // high, not only from the following edge.
    if (Reset) begin
      ifc.instr_ready = 1'b0;
      RegWrite        = 1'b0;
      ifc.done        = 1'b0;
    end
  end

  assign accept = (state_q == ST_IDLE) && ifc.instr_valid;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      read1_q   <= '0;
      read2_q   <= '0;
      write_r_q <= '0;
    end else begin
      state_q <= state_d;
      // Read addresses are loaded at handshake so they are already valid
      // throughout READ, then hold until the next instruction.
      if (accept) begin
        instr_q <= ifc.instr;
        read1_q <= get_rs(ifc.instr);
        read2_q <= get_rt(ifc.instr);
      end
      if (state_q == ST_READ) begin
        a_q <= ReadD1;
        b_q <= ReadD2;
      end
      // WriteR gets its own register so it holds after the next handshake
      // replaces instr_q.
      if (state_q == ST_EXEC) begin
        result_q  <= alu_res[W-1:0];
        carry_q   <= alu_res[W];
        zero_q    <= alu_zero;
        write_r_q <= get_rd(instr_q);
      end
    end
  end

  assign Read1      = read1_q;
  assign Read2      = read2_q;
  assign WriteR     = write_r_q;
  assign WriteD     = result_q;
  assign ifc.result = result_q;
  assign ifc.carry  = carry_q;
  assign ifc.zero   = zero_q;

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multicycle initiator for the 4 x 8-bit `register` file: accepts one 8-bit instruction per handshake, reads the source operands from the register file, computes the result and writes it back. It sits between the instruction source (fetch logic or bench) and `register`, driving the register file's `Read1`/`Read2`/`WriteR`/`WriteD`/`RegWrite` ports and consuming `ReadD1`/`ReadD2`.

## Interface
Parameters:
- `W`, 8, data width; must match `register`.

Ports:
- Clocking and reset: one clock, `clk`. `Reset` is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous reset, active-high.
- `instr_valid`  in  1  instruction present.
- `instr`  in  8  `op[7:6]`, `rs[5:4]`, `rt[3:2]`, `rd[1:0]`.
- `instr_ready`  out  1  sequencer idle; transfer occurs when `instr_valid & instr_ready`.
- `Read1`  out  2  register file read address A (= `rs`).
- `Read2`  out  2  register file read address B (= `rt`).
- `ReadD1`  in  W  register file read data A (combinational read).
- `ReadD2`  in  W  register file read data B.
- `RegWrite`  out  1  register file write enable.
- `WriteR`  out  2  write address (= `rd`).
- `WriteD`  out  W  write data.
- `done`  out  1  one-cycle pulse; instruction retired.
- `result`  out  W  value written; valid while `done`.
- `carry`  out  1  carry (ADD) or borrow (SUB); 0 for MOV/LI; valid while `done`.
- `zero`  out  1  `result == 0`; valid while `done`.

## Operation
- Opcodes: `00` ADD `rd = rs + rt`; `01` SUB `rd = rs - rt`; `10` MOV `rd = rs`; `11` LI `rd = {4'b0, instr[5:2]}` (no operand read used).
- FSM states: `IDLE -> READ -> EXEC -> WRITE -> IDLE`. No other transitions.
- IDLE: `instr_ready = 1`. On handshake, latch `instr`, go to READ.
- READ: drive `Read1 = rs`, `Read2 = rt`. Capture `ReadD1`/`ReadD2` into operand registers at the end of the cycle.
- EXEC: ALU computes a 9-bit sum or difference. The low 8 bits are registered as `result`. Bit 8 is registered as `carry`: carry-out for ADD, borrow for SUB (`rs < rt` unsigned). `zero` is registered.
- WRITE: `RegWrite = 1`, `WriteR = rd`, `WriteD = result`, `done = 1`, each for exactly one cycle. Then return to IDLE.
- Outside READ, `Read1`/`Read2` hold their last values. Outside WRITE, `RegWrite = 0`. `WriteR`/`WriteD` hold their last values.
- No hazard logic is needed: the write commits at the edge ending WRITE, before any later instruction's READ.
- `rd` equal to `rs` or `rt` is legal; the old value is read and the new value is written.

## Timing
- Handshake at edge k produces: READ in cycle k+1, EXEC in k+2, WRITE/`done` in k+3. `instr_ready` is high again in cycle k+4.
- Maximum throughput is one instruction per 4 cycles. `instr_ready = 0` in READ, EXEC and WRITE. A `instr_valid` held high is ignored until IDLE.
- Reset values: state IDLE; `RegWrite`, `done`, `carry`, `zero` = 0; `Read1`, `Read2`, `WriteR` = 0; `WriteD`, `result` = 0.
- `instr_ready` is 0 while `Reset` is high.
- Reset mid-instruction aborts the instruction. If `Reset` is high in any cycle, `RegWrite` and `done` are 0 in that cycle, including the WRITE cycle. The next cycle is IDLE.

## Structure
- Shared package holds: opcode constants `OP_ADD`/`OP_SUB`/`OP_MOV`/`OP_LI`, the FSM state encoding (2-bit), and the instruction field bit positions.
- One sub-module, `regfile_seq_alu`: combinational. Inputs are op, a, b, imm. Outputs are the 9-bit result and zero.
- The top level holds the FSM, the instruction latch, the operand registers and the output registers.

## Test plan
The bench instantiates a real `register` driven by the sequencer. All values below are decimal unless noted.
- LI r1,5 then LI r2,3: `RegWrite` is high one cycle each, with `WriteR=1, WriteD=5` then `WriteR=2, WriteD=3`. `done` comes 3 cycles after each handshake.
- ADD r3=r1+r2: in the READ cycle `Read1=1`, `Read2=2`. In WRITE, `WriteD=8`, `carry=0`, `zero=0`. A later MOV r0=r3 writes 8 to r0.
- SUB r0=r2-r1 gives `result=0xFE`, `carry=1`. SUB r0=r1-r1 gives `result=0`, `zero=1`, `carry=0`.
- LI r1,15, then five ADD r1=r1+r1: results are 30, 60, 120, 240, 224 (0xE0). `carry=1` only on the fifth.
- `instr_valid` held high with two queued instructions: handshakes occur exactly 4 cycles apart. `instr_ready` is low in the three intermediate cycles.
- ADD accepted, then `Reset` pulsed in its EXEC cycle: there is no `RegWrite` and no `done`. `instr_ready` is 0 during reset and 1 in the following cycle. The register file reads all zeros.
